// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//
// Serial bit-pattern detector with a run-time loadable N-bit pattern.
// Consumes one bit of x on every rising edge where in_valid is high and
// tracks the longest matched pattern prefix. This gives a KMP-style
// matched-prefix length without a precomputed failure table.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   x            in   serial data bit
//   in_valid     in   x is consumed on this edge only when high
//   overlap      in   1 = overlapping matches, 0 = each match needs N fresh bits
//   pat_load     in   load pat_in as the new pattern and clear all history
//   pat_in       in   [N-1:0] new pattern; bit N-1 is received first
//   mealy        out  combinational match: the current x completes the pattern
//   moore        out  registered match: high while curstate == N
//   curstate     out  [SW-1:0] registered matched-prefix length, 0..N
//   match_count  out  [CNT_W-1:0] saturating count of mealy matches
// -----------------------------------------------------------------------------
module seq_detector_param #(
  parameter int             N            = 4,
  parameter logic [N-1:0]   INIT_PATTERN = 4'b1001,
  parameter int             CNT_W        = 8,
  parameter int             SW           = $clog2(N+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             in_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
  output logic             mealy,
  output logic             moore,
  output logic [SW-1:0]    curstate,
  output logic [CNT_W-1:0] match_count
);

  typedef logic [SW-1:0]    st_t;
  typedef logic [SW:0]      lim_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam lim_t LIM_MAX = lim_t'(N-1);
  localparam st_t  ST_FULL = st_t'(N);
  localparam cnt_t CNT_MAX = {CNT_W{1'b1}};

  // Mask selecting the k newest (lowest) bits of an N-bit window.
  function automatic logic [N-1:0] low_mask(input int k);
    return {N{1'b1}} >> (N - k);
  endfunction

  logic [N-1:0] r_pattern;
  logic [N-2:0] r_hist;      // N-1 newest consumed bits, newest in bit 0
  st_t          r_avail;     // usable consumed bits, saturates at N
  st_t          r_state;
  logic         r_moore;
  cnt_t         r_count;

  logic [N-1:0] w_win;       // r_hist with the current x appended
  lim_t         w_avail_ext;
  lim_t         w_lim;       // longest prefix length allowed this edge
  logic         w_mealy;
  st_t          w_pfx;
  st_t          w_next_state;
  st_t          w_next_avail;

  // Match detection and next matched-prefix / availability computation.
  always_comb begin
    w_win       = {r_hist, x};
    w_avail_ext = {1'b0, r_avail};

    if (w_avail_ext >= LIM_MAX) begin
      w_lim = LIM_MAX;
    end else begin
      w_lim = w_avail_ext + lim_t'(1);
    end

    w_mealy = in_valid & ~pat_load & ~reset & (w_avail_ext >= LIM_MAX) &
              (w_win == r_pattern);

    // Largest k whose newest k window bits equal the first k pattern bits.
    // Only bits consumed since the last clear may take part (w_lim).
    w_pfx = '0;
    for (int k = 1; k < N; k++) begin
      if ((lim_t'(k) <= w_lim) &&
          ((w_win & low_mask(k)) == (r_pattern >> (N - k)))) begin
        w_pfx = st_t'(k);
      end else begin
        w_pfx = w_pfx;
      end
    end

    if (w_mealy) begin
      w_next_state = ST_FULL;
    end else begin
      w_next_state = w_pfx;
    end

    // A non-overlapping match forgets all history so the next match
    // has to be built from N fresh bits.
    if (w_mealy && !overlap) begin
      w_next_avail = '0;
    end else if (r_avail == ST_FULL) begin
      w_next_avail = r_avail;
    end else begin
      w_next_avail = r_avail + st_t'(1);
    end
  end

  // Pattern, history, prefix state, Moore flag and match counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pattern <= INIT_PATTERN;
      r_hist    <= '0;
      r_avail   <= '0;
      r_state   <= '0;
      r_moore   <= 1'b0;
      r_count   <= '0;
    end else if (pat_load) begin
      // Load wins over in_valid: the x on this edge is dropped.
      r_pattern <= pat_in;
      r_hist    <= '0;
      r_avail   <= '0;
      r_state   <= '0;
      r_moore   <= 1'b0;
      r_count   <= '0;
    end else if (in_valid) begin
      r_hist  <= w_win[N-2:0];
      r_avail <= w_next_avail;
      r_state <= w_next_state;
      r_moore <= w_mealy;   // next state reaches N only through a match
      if (w_mealy && (r_count != CNT_MAX)) begin
        r_count <= r_count + cnt_t'(1);
      end else begin
        r_count <= r_count;
      end
    end else begin
      r_hist    <= r_hist;
      r_avail   <= r_avail;
      r_state   <= r_state;
      r_moore   <= r_moore;
      r_count   <= r_count;
    end
  end

  assign mealy       = w_mealy;
  assign moore       = r_moore;
  assign curstate    = r_state;
  assign match_count = r_count;

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  logic       clk;
  logic       reset;
  logic       x;
  logic       in_valid;
  logic       overlap;
  logic       pat_load;
  logic [3:0] pat_in;

  logic       mealy, moore;
  logic [2:0] curstate;
  logic [7:0] match_count;

  logic       mealy2, moore2;
  logic [2:0] curstate2;
  logic [1:0] match_count2;

  int checks = 0;
  int errors = 0;

  seq_detector_param #(.N(4), .INIT_PATTERN(4'b1001), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .x(x), .in_valid(in_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .mealy(mealy), .moore(moore),
    .curstate(curstate), .match_count(match_count)
  );

  seq_detector_param #(.N(4), .INIT_PATTERN(4'b1001), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .x(x), .in_valid(in_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .mealy(mealy2), .moore(moore2),
    .curstate(curstate2), .match_count(match_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       x;
    logic       v;
    logic       ov;
    logic       pl;
    logic [3:0] pi;
    logic       em;
    logic       emo;
    logic [2:0] ecs;
    logic [7:0] ecnt;
  } vec_t;

  vec_t vecs[$];

  // Test 1/2 stream, bit 0 first (leftmost).
  logic [17:0] s1  = 18'b010010011000010010;
  int          cs1[18] = '{0,1,2,3,4,2,3,4,1,2,3,0,0,1,2,3,4,2};
  int          cn1[18] = '{0,0,0,0,1,1,1,2,2,2,2,2,2,2,2,2,3,3};
  int          cs2[18] = '{0,1,2,3,4,0,0,1,1,2,3,0,0,1,2,3,4,0};
  int          cn2[18] = '{0,0,0,0,1,1,1,1,1,1,1,1,1,1,1,1,2,2};
  logic [6:0]  s4  = 7'b1101101;
  int          cs4[7]  = '{1,2,3,4,2,3,4};
  int          cn4[7]  = '{0,0,0,1,1,1,2};

  logic b5, em5;
  int   m5, ecs5, sat5;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic xx, input logic v, input logic ov,
                              input logic pl, input logic [3:0] pi,
                              input int cs, input int cnt);
    vec_t t;
    t.x = xx; t.v = v; t.ov = ov; t.pl = pl; t.pi = pi;
    t.ecs  = 3'(cs);
    t.ecnt = 8'(cnt);
    t.emo  = (cs == 4);
    t.em   = (cs == 4) && v && !pl;
    return t;
  endfunction

  task automatic add(input logic xx, input logic v, input logic ov, input logic pl,
                     input logic [3:0] pi, input int cs, input int cnt);
    vecs.push_back(mk(xx, v, ov, pl, pi, cs, cnt));
  endtask

  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    x = t.x; in_valid = t.v; overlap = t.ov; pat_load = t.pl; pat_in = t.pi;
    #1;
    chk({tag, "_mealy"}, 32'(mealy), 32'(t.em));
    @(posedge clk);
    #1;
    chk({tag, "_curstate"}, 32'(curstate), 32'(t.ecs));
    chk({tag, "_moore"}, 32'(moore), 32'(t.emo));
    chk({tag, "_count"}, 32'(match_count), 32'(t.ecnt));
  endtask

  initial begin
    // ---------------- Reset state ----------------
    reset = 1'b1; x = 1'b1; in_valid = 1'b1; overlap = 1'b1;
    pat_load = 1'b0; pat_in = 4'b0000;
    #1;
    chk("rst_mealy", 32'(mealy), 32'd0);
    chk("rst_curstate", 32'(curstate), 32'd0);
    chk("rst_moore", 32'(moore), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);
    @(negedge clk);
    reset = 1'b0; x = 1'b0; in_valid = 1'b0;

    // ---------------- Vector table ----------------
    // Test 1: overlap, pattern 1001 from reset.
    for (int i = 0; i < 18; i++) add(s1[17-i], 1'b1, 1'b1, 1'b0, 4'b0000, cs1[i], cn1[i]);
    // Test 2: same stream, non-overlapping.
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'b1001, 0, 0);
    for (int i = 0; i < 18; i++) add(s1[17-i], 1'b1, 1'b0, 1'b0, 4'b0000, cs2[i], cn2[i]);
    // Test 3: in_valid toggling; bits with in_valid=0 would break the match.
    add(1'b1, 1'b1, 1'b1, 1'b1, 4'b1001, 0, 0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1, 0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1, 0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 2, 0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 2, 0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 3, 0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 3, 0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4, 1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4, 1);
    add(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4, 1);
    // Test 4: load 1101 together with a valid x, which must be dropped.
    add(1'b1, 1'b1, 1'b1, 1'b1, 4'b1101, 0, 0);
    for (int i = 0; i < 7; i++) add(s4[6-i], 1'b1, 1'b1, 1'b0, 4'b0000, cs4[i], cn4[i]);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // ---------------- Test 5: counter saturation (CNT_W=2) ----------------
    apply(mk(1'b0, 1'b1, 1'b1, 1'b1, 4'b1001, 0, 0), "t5_load");
    m5 = 0;
    for (int i = 0; i < 16; i++) begin
      b5  = (i % 3 == 0);
      em5 = (i >= 3) && (i % 3 == 0);
      if (i < 3)           ecs5 = i + 1;
      else if (i % 3 == 0) ecs5 = 4;
      else if (i % 3 == 1) ecs5 = 2;
      else                 ecs5 = 3;
      @(negedge clk);
      x = b5; in_valid = 1'b1; overlap = 1'b1; pat_load = 1'b0;
      #1;
      chk($sformatf("t5_b%0d_mealy", i), 32'(mealy), 32'(em5));
      chk($sformatf("t5_b%0d_mealy2", i), 32'(mealy2), 32'(em5));
      if (em5) m5++;
      sat5 = (m5 > 3) ? 3 : m5;
      @(posedge clk);
      #1;
      chk($sformatf("t5_b%0d_curstate", i), 32'(curstate), 32'(ecs5));
      chk($sformatf("t5_b%0d_count", i), 32'(match_count), 32'(m5));
      chk($sformatf("t5_b%0d_count2", i), 32'(match_count2), 32'(sat5));
      chk($sformatf("t5_b%0d_moore2", i), 32'(moore2), 32'(em5));
    end
    chk("t5_final_count2", 32'(match_count2), 32'd3);

    // ---------------- Test 6: asynchronous reset mid-sequence ----------------
    apply(mk(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1, 5), "t6_b0");
    apply(mk(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 2, 5), "t6_b1");
    apply(mk(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 3, 5), "t6_b2");
    @(negedge clk);
    x = 1'b1; in_valid = 1'b1; overlap = 1'b1; pat_load = 1'b0;
    #1;
    chk("t6_pre_mealy", 32'(mealy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_mealy", 32'(mealy), 32'd0);
    chk("t6_async_curstate", 32'(curstate), 32'd0);
    chk("t6_async_moore", 32'(moore), 32'd0);
    chk("t6_async_count", 32'(match_count), 32'd0);
    chk("t6_async_count2", 32'(match_count2), 32'd0);
    @(posedge clk);
    #1;
    chk("t6_hold_curstate", 32'(curstate), 32'd0);
    @(negedge clk);
    reset = 1'b0; x = 1'b1; in_valid = 1'b1;
    #1;
    chk("t6_post_mealy", 32'(mealy), 32'd0);
    @(posedge clk);
    #1;
    chk("t6_post_curstate", 32'(curstate), 32'd1);
    chk("t6_post_moore", 32'(moore), 32'd0);
    chk("t6_post_count", 32'(match_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
